// File: rtl/rev_pe_pkg.sv
// Shared types, mode encodings and the mod-3 residue helper for the reversible PE.
package rev_pe_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  localparam int unsigned MOD3_MAX_W = 64;

  // Residue mod 3 of an up-to-64-bit value, folded MSB first: r = (2r + bit) mod 3
  function automatic logic [1:0] mod3(input logic [MOD3_MAX_W-1:0] x);
    logic [1:0] r;
    logic [2:0] t;
    r = 2'd0;
    for (int i = MOD3_MAX_W - 1; i >= 0; i--) begin
      t = {r, x[i]};
      r = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rev_pe_param_if.sv
// Host-side bus of the reversible PE: buffer ports, run control, test injection and error status.
interface rev_pe_param_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(DEPTH),
  parameter int unsigned ERRCNT_W = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                  wen;
  logic [AW-1:0]         waddr;
  logic [2*DATA_W-1:0]   wdata;
  logic                  ren;
  logic [AW-1:0]         raddr;
  logic [ACC_W-1:0]      rdata;
  logic                  rvalid;
  logic                  start;
  logic                  mode;
  logic                  busy;
  logic                  done;
  logic                  inj_mul;
  logic                  inj_add;
  logic                  err_mul;
  logic                  err_add;
  logic [ERRCNT_W-1:0]   err_mul_cnt;
  logic [ERRCNT_W-1:0]   err_add_cnt;
  logic                  err_clr;

  modport master (
    output wen, waddr, wdata, ren, raddr, start, mode, inj_mul, inj_add, err_clr,
    input  rdata, rvalid, busy, done, err_mul, err_add, err_mul_cnt, err_add_cnt
  );

  modport slave (
    input  wen, waddr, wdata, ren, raddr, start, mode, inj_mul, inj_add, err_clr,
    output rdata, rvalid, busy, done, err_mul, err_add, err_mul_cnt, err_add_cnt
  );
endinterface

// File: rtl/rev_mac_lane.sv
// Three-stage multiply/accumulate lane with residue check on the product and inverse-subtract check on the sum.
module rev_mac_lane
  import rev_pe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              inj_mul,
  input  logic              inj_add,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  output logic              mul_err,
  output logic              add_err
);
  localparam int unsigned PW = 2 * DATA_W;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s2_valid;
  logic [PW-1:0]     s2_p;
  logic [ACC_W-1:0]  acc;

  logic [PW-1:0]     p_inj;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [3:0]        rr;
  logic              mul_bad;
  logic [ACC_W-1:0]  acc_prev;
  logic [ACC_W-1:0]  sum_inj;
  logic              add_bad;

  // Product with optional LSB flip, and its residue cross-check
  always_comb begin
    p_inj   = (PW'(s1_a) * PW'(s1_b)) ^ PW'(inj_mul);
    ra      = mod3(64'(s1_a));
    rb      = mod3(64'(s1_b));
    rr      = 4'(ra) * 4'(rb);
    mul_bad = mod3(64'(rr)) != mod3(64'(p_inj));
  end

  // Sum with optional LSB flip, and the subtract-back check against the product
  always_comb begin
    acc_prev = (mode == MODE_MAC) ? acc : '0;
    sum_inj  = (acc_prev + ACC_W'(s2_p)) ^ ACC_W'(inj_add);
    add_bad  = (sum_inj - acc_prev) != ACC_W'(s2_p);
  end

  // Stage 1: operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= a;
        s1_b <= b;
      end
    end
  end

  // Stage 2: product register and multiplier error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      mul_err  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      mul_err  <= s1_valid && mul_bad;
      if (s1_valid) s2_p <= p_inj;
    end
  end

  // Stage 3: result register, accumulator and adder error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res       <= '0;
      add_err   <= 1'b0;
      acc       <= '0;
    end else begin
      res_valid <= s2_valid;
      add_err   <= s2_valid && add_bad;
      if (s2_valid) res <= sum_inj;
      if (acc_clr) acc <= '0;
      else if (s2_valid && mode == MODE_MAC) acc <= sum_inj;
    end
  end

endmodule

// File: rtl/rev_pe_param.sv
// Reversible PE top: run FSM, operand/result buffers, host access and error status.
module rev_pe_param
  import rev_pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(DEPTH),
  parameter int unsigned ERRCNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  rev_pe_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = 2 * DATA_W;

  state_t           state;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             mode_q;
  logic             land_q;
  logic [PW-1:0]    opbuf  [DEPTH];
  logic [ACC_W-1:0] outbuf [DEPTH];

  logic             start_ok;
  logic             idle;
  logic [PW-1:0]    op_rd;
  logic [ACC_W-1:0] res;
  logic             res_valid;
  logic             mul_err;
  logic             add_err;

  assign idle     = (state == IDLE);
  assign start_ok = idle && bus.start;
  assign op_rd    = opbuf[rd_ptr];

  rev_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_clr  (start_ok),
    .mode     (mode_q),
    .in_valid (state == RUN),
    .a        (op_rd[DATA_W-1:0]),
    .b        (op_rd[PW-1:DATA_W]),
    .inj_mul  (bus.inj_mul),
    .inj_add  (bus.inj_add),
    .res      (res),
    .res_valid(res_valid),
    .mul_err  (mul_err),
    .add_err  (add_err)
  );

  // Run sequencing with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      mode_q   <= MODE_MUL;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= RUN;
          rd_ptr   <= '0;
          mode_q   <= bus.mode;
          bus.busy <= 1'b1;
        end
        RUN: begin
          rd_ptr <= rd_ptr + AW'(1);
          if (rd_ptr == AW'(DEPTH - 1)) state <= DRAIN;
        end
        DRAIN: if (land_q) begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result write pointer; land_q marks the cycle after the final result is stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      land_q <= 1'b0;
    end else begin
      land_q <= res_valid && (wr_ptr == AW'(DEPTH - 1));
      if (res_valid) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Buffer storage is never reset so contents survive an aborted run
  always_ff @(posedge clk) begin
    if (bus.wen && idle) opbuf[bus.waddr] <= bus.wdata;
    if (res_valid) outbuf[wr_ptr] <= res;
  end

  // Host readback, only honoured while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= bus.ren && idle;
      if (bus.ren && idle) bus.rdata <= outbuf[bus.raddr];
    end
  end

  // Sticky flags and saturating counters; clear wins over a coincident error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_mul     <= 1'b0;
      bus.err_add     <= 1'b0;
      bus.err_mul_cnt <= '0;
      bus.err_add_cnt <= '0;
    end else if (bus.err_clr) begin
      bus.err_mul     <= 1'b0;
      bus.err_add     <= 1'b0;
      bus.err_mul_cnt <= '0;
      bus.err_add_cnt <= '0;
    end else begin
      if (mul_err) begin
        bus.err_mul <= 1'b1;
        if (bus.err_mul_cnt != '1) bus.err_mul_cnt <= bus.err_mul_cnt + ERRCNT_W'(1);
      end
      if (add_err) begin
        bus.err_add <= 1'b1;
        if (bus.err_add_cnt != '1) bus.err_add_cnt <= bus.err_add_cnt + ERRCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rev_pe_param.sv
// Scoreboard bench for rev_pe_param: default-sized instance plus a DATA_W=4/DEPTH=16/ERRCNT_W=2 instance.
module tb_rev_pe_param;
  import rev_pe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rev_pe_param_if #(.DATA_W(8), .DEPTH(8),  .ACC_W(19), .ERRCNT_W(8)) if0 ();
  rev_pe_param_if #(.DATA_W(4), .DEPTH(16), .ACC_W(12), .ERRCNT_W(2)) if1 ();

  rev_pe_param #(.DATA_W(8), .DEPTH(8),  .ACC_W(19), .ERRCNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rev_pe_param #(.DATA_W(4), .DEPTH(16), .ACC_W(12), .ERRCNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp0_q[$];
  logic [63:0] exp1_q[$];

  int mul_a[8] = '{3, 255, 0, 1, 2, 16, 9, 255};
  int mul_b[8] = '{5, 255, 7, 1, 128, 16, 9, 1};
  logic [63:0] mul_e[8] = '{15, 65025, 0, 1, 256, 256, 81, 255};
  int two[8]   = '{2, 2, 2, 2, 2, 2, 2, 2};
  int three[8] = '{3, 3, 3, 3, 3, 3, 3, 3};
  logic [63:0] mac_e[8];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  task automatic mon0();
    forever begin
      @(negedge clk);
      if (if0.rvalid === 1'b1) begin
        if (exp0_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rvalid0_unexpected: got rvalid=1 rdata=%0d, expected no read response", if0.rdata);
        end else check("rdata0", 64'(if0.rdata), exp0_q.pop_front());
      end
    end
  endtask

  task automatic mon1();
    forever begin
      @(negedge clk);
      if (if1.rvalid === 1'b1) begin
        if (exp1_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rvalid1_unexpected: got rvalid=1 rdata=%0d, expected no read response", if1.rdata);
        end else check("rdata1", 64'(if1.rdata), exp1_q.pop_front());
      end
    end
  endtask

  task automatic load0(input int av[8], input int bv[8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if0.wen = 1'b1; if0.waddr = 3'(i); if0.wdata = {8'(bv[i]), 8'(av[i])};
    end
    @(negedge clk); if0.wen = 1'b0;
  endtask

  task automatic read0(input logic [63:0] ev[8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp0_q.push_back(ev[i]); if0.ren = 1'b1; if0.raddr = 3'(i);
    end
    @(negedge clk); if0.ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic read0_at(input int addr, input logic [63:0] e);
    @(negedge clk);
    exp0_q.push_back(e); if0.ren = 1'b1; if0.raddr = 3'(addr);
    @(negedge clk); if0.ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic read1_at(input int addr, input logic [63:0] e);
    @(negedge clk);
    exp1_q.push_back(e); if1.ren = 1'b1; if1.raddr = 4'(addr);
    @(negedge clk); if1.ren = 1'b0;
    @(negedge clk);
  endtask

  // Start a run on instance 0; optional one-cycle inj_mul and host pokes while busy
  task automatic run0(input logic m, input int inj_cyc, input bit poke);
    int cyc;
    cyc = -1;
    @(negedge clk); if0.start = 1'b1; if0.mode = m;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if0.start   = poke && (n == 3);
      if0.wen     = poke && (n == 3); if0.waddr = 3'd7; if0.wdata = 16'h0202;
      if0.ren     = poke && (n == 3); if0.raddr = 3'd0;
      if0.inj_mul = (n == inj_cyc);
      if (n == 1) check("busy_cycle1", 64'(if0.busy), 1);
      if (if0.done === 1'b1) begin cyc = n; break; end
    end
    if0.start = 1'b0; if0.wen = 1'b0; if0.ren = 1'b0; if0.inj_mul = 1'b0;
    check("done_cycle0", 64'(cyc), 13);
    @(negedge clk);
    check("done_one_cycle0", 64'(if0.done), 0);
    check("busy_after0", 64'(if0.busy), 0);
  endtask

  task automatic run1(input logic m);
    int cyc;
    cyc = -1;
    @(negedge clk); if1.start = 1'b1; if1.mode = m;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if1.start = 1'b0;
      if (if1.done === 1'b1) begin cyc = n; break; end
    end
    if1.start = 1'b0;
    check("done_cycle1", 64'(cyc), 21);
  endtask

  task automatic clr_err0();
    @(negedge clk); if0.err_clr = 1'b1;
    @(negedge clk); if0.err_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    if0.wen = 0; if0.waddr = 0; if0.wdata = 0; if0.ren = 0; if0.raddr = 0; if0.start = 0;
    if0.mode = 0; if0.inj_mul = 0; if0.inj_add = 0; if0.err_clr = 0;
    if1.wen = 0; if1.waddr = 0; if1.wdata = 0; if1.ren = 0; if1.raddr = 0; if1.start = 0;
    if1.mode = 0; if1.inj_mul = 0; if1.inj_add = 0; if1.err_clr = 0;
    for (int i = 0; i < 8; i++) mac_e[i] = 64'(6 * (i + 1));
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(if0.busy), 0);
    check("rst_done", 64'(if0.done), 0);
    check("rst_rvalid", 64'(if0.rvalid), 0);
    check("rst_rdata", 64'(if0.rdata), 0);
    check("rst_err_mul", 64'(if0.err_mul), 0);
    check("rst_err_add", 64'(if0.err_add), 0);
    check("rst_mul_cnt", 64'(if0.err_mul_cnt), 0);
    check("rst_add_cnt", 64'(if0.err_add_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      mon0();
      mon1();
    join_none

    // MUL mode on the reference vector
    load0(mul_a, mul_b);
    run0(MODE_MUL, 0, 0);
    read0(mul_e);
    check("mul_err_mul", 64'(if0.err_mul), 0);
    check("mul_err_add", 64'(if0.err_add), 0);
    check("mul_mul_cnt", 64'(if0.err_mul_cnt), 0);
    check("mul_add_cnt", 64'(if0.err_add_cnt), 0);

    // MAC mode, then a second MAC run must restart the accumulator
    load0(two, three);
    run0(MODE_MAC, 0, 0);
    read0(mac_e);
    run0(MODE_MAC, 0, 0);
    read0_at(0, 6);
    read0_at(7, 48);

    // One corrupted product stage (entry 2)
    run0(MODE_MUL, 4, 0);
    check("injm_err_mul", 64'(if0.err_mul), 1);
    check("injm_mul_cnt", 64'(if0.err_mul_cnt), 1);
    check("injm_err_add", 64'(if0.err_add), 0);
    read0_at(2, 7);
    read0_at(3, 6);

    clr_err0();
    check("clr_err_mul", 64'(if0.err_mul), 0);
    check("clr_mul_cnt", 64'(if0.err_mul_cnt), 0);

    // Sum corrupted for a whole run
    if0.inj_add = 1'b1;
    run0(MODE_MUL, 0, 0);
    if0.inj_add = 1'b0;
    check("inja_add_cnt", 64'(if0.err_add_cnt), 8);
    check("inja_err_add", 64'(if0.err_add), 1);
    check("inja_err_mul", 64'(if0.err_mul), 0);
    read0_at(0, 7);
    clr_err0();
    check("clr_add_cnt", 64'(if0.err_add_cnt), 0);

    // Host writes, reads and start while busy are all ignored
    load0(mul_a, mul_b);
    run0(MODE_MUL, 0, 1);
    seen = 1'b0;
    repeat (20) @(negedge clk) if (if0.busy === 1'b1) seen = 1'b1;
    check("no_second_run", 64'(seen), 0);
    read0(mul_e);

    // Abort at RUN cycle 4, then rerun from the preserved operand buffer
    load0(two, three);
    run0(MODE_MUL, 0, 0);
    load0(mul_a, mul_b);
    @(negedge clk); if0.start = 1'b1; if0.mode = MODE_MUL;
    @(negedge clk); if0.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(if0.busy), 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) @(negedge clk) if (if0.done === 1'b1) seen = 1'b1;
    check("abort_no_done", 64'(seen), 0);
    read0_at(0, 6);
    run0(MODE_MUL, 0, 0);
    read0(mul_e);

    // Wider-depth instance: MAC of (15,15) x16, then counter saturation
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); if1.wen = 1'b1; if1.waddr = 4'(i); if1.wdata = 8'hFF;
    end
    @(negedge clk); if1.wen = 1'b0;
    run1(MODE_MAC);
    read1_at(0, 225);
    read1_at(7, 1800);
    read1_at(15, 3600);
    if1.inj_add = 1'b1;
    run1(MODE_MUL);
    if1.inj_add = 1'b0;
    @(negedge clk);
    check("sat_add_cnt", 64'(if1.err_add_cnt), 3);
    check("sat_err_add", 64'(if1.err_add), 1);
    read1_at(0, 224);

    repeat (3) @(negedge clk);
    check("q0_drained", 64'(exp0_q.size()), 0);
    check("q1_drained", 64'(exp1_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rev_pe_param.md
Name: rev_pe_param

Overview:
Parametrised single-clock successor of the two-phase reversible PE. It loads a DEPTH-entry operand buffer of {b,a} pairs from a host port, streams them through a pipelined multiply and accumulate datapath, and writes results to an output buffer. Each datapath stage carries a reversibility check: mod-3 residue on the multiplier, inverse subtraction on the adder. Errors are reported as sticky flags plus saturating counters. The block sits behind the SPI slave in place of the fixed 8-entry, 8-bit PE.

Parameters:
DATA_W, 8, operand width (a and b each)
DEPTH, 8, entries in each buffer (power of 2, >=2)
ACC_W, 2*DATA_W+$clog2(DEPTH), result/accumulator width
ERRCNT_W, 8, width of each error counter

Ports:
clk  in  1  single system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
wen  in  1  host write strobe
waddr  in  $clog2(DEPTH)  operand buffer write address
wdata  in  2*DATA_W  {b,a}
ren  in  1  host read strobe, output buffer
raddr  in  $clog2(DEPTH)  output buffer read address
rdata  out  ACC_W  read data
rvalid  out  1  rdata valid
start  in  1  begin run, one-cycle pulse
mode  in  1  0=MUL (out=a*b), 1=MAC (out=running sum of a*b), sampled on accepted start
busy  out  1  high in RUN/DRAIN
done  out  1  one-cycle pulse at end of run
inj_mul  in  1  test: flip product LSB before the check
inj_add  in  1  test: flip sum LSB before the check
err_mul  out  1  sticky multiplier-check error
err_add  out  1  sticky adder-check error
err_mul_cnt  out  ERRCNT_W  saturating count of mul errors
err_add_cnt  out  ERRCNT_W  saturating count of add errors
err_clr  in  1  clear flags and counters

Behaviour:
- Reset: state=IDLE; busy, done, rvalid, err_* = 0; counters = 0; rdata = 0; pipeline valids = 0; buffer contents are not reset.
- States: IDLE -> RUN on start; RUN -> DRAIN after DEPTH reads; DRAIN -> DONE when the last write lands; DONE -> IDLE after 1 cycle, with done=1 in DONE.
- start outside IDLE is ignored. mode is latched on the accepted start.
- RUN: rd_ptr goes 0..DEPTH-1, one read per cycle. Buffer read latency is 1.
- Pipeline, for entry read in RUN cycle k:
  - k+1: operands registered.
  - k+2: product registered, with mul check.
  - k+3: sum registered, with add check, and written to out[k].
- Start pulse at cycle 0 gives done at cycle DEPTH+5; busy covers cycles 1..DEPTH+4.
- Arithmetic: p = a*b, unsigned, 2*DATA_W bits, zero-extended to ACC_W.
  - MUL mode: s = p.
  - MAC mode: s = acc + p, wrapping mod 2^ACC_W. acc resets to 0 on each accepted start.
- Mul check: (a mod 3)*(b mod 3) mod 3 must equal p' mod 3, where p' = p ^ inj_mul. A mismatch on a valid stage is an error.
- Add check: s' - acc_prev must equal p, where s' = s ^ inj_add and acc_prev=0 in MUL mode. A mismatch on a valid stage is an error. The stored result is s'.
- Error detection is gated by stage valid; an idle pipeline never flags.
- Error flags are sticky until err_clr. Counters saturate at all-ones.
- err_clr has priority over an error in the same cycle: the result is 0.
- Host write: accepted only in IDLE. wen while busy is dropped, with no other side effect.
- Host read: accepted only in IDLE. rvalid=1 and rdata=out[raddr] the next cycle. ren while busy gives rvalid=0.
- Address wrap: waddr and raddr are used modulo DEPTH by width. rd_ptr and wr_ptr wrap to 0 at run end.
- Reset mid-run aborts immediately: no done pulse, and output buffer entries already written keep their values.

Decomposition:
- Package rev_pe_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - MODE_MUL=1'b0, MODE_MAC=1'b1;
  - function mod3 (parametrised by width via a loop).
- Sub-module rev_mac_lane (DATA_W, ACC_W): the three pipeline stages, accumulator, both checks and injection. Outputs are the result, its valid, and per-cycle mul_err/add_err pulses.
- Top level owns the FSM, pointers, both buffers, host ports and the error flags/counters.

Test Plan:
- Defaults, MUL mode: load pairs (3,5),(255,255),(0,7),(1,1),(2,128),(16,16),(9,9),(255,1); start -> done at cycle 13; readback 15,65025,0,1,256,256,81,255; err_* = 0.
- MAC mode, all pairs (2,3) -> readback 6,12,...,48. A second MAC run restarts at 6, not 54.
- inj_mul held for one valid stage -> err_mul=1, err_mul_cnt=1, err_add=0.
- Raise err_clr alone -> flags and counter return to 0.
- inj_add held for a whole run -> err_add_cnt=8. With ERRCNT_W=2, the count holds at 3.
- wen, ren and start asserted during busy -> buffer unchanged, rvalid=0, no second run.
- rst_n low at RUN cycle 4 -> busy=0 and no done; a subsequent full run is correct.
- DEPTH=16, DATA_W=4: all pairs (15,15) in MAC mode -> final result 3600, which fits ACC_W=12.
